// File: rtl/grain128_ks_xor.sv
// Keystream consumer for grain128: packs serial keystream bits MSB-first into
// words and XORs each word with one handshaked data word (encrypt or decrypt).
module grain128_ks_xor #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ks_rdy,
    input  logic              ks_z,
    output logic              ks_gen,
    input  logic              pt_valid,
    input  logic [WORD_W-1:0] pt_data,
    input  logic              pt_last,
    output logic              pt_ready,
    output logic              ct_valid,
    output logic [WORD_W-1:0] ct_data,
    output logic              ct_last,
    input  logic              ct_ready,
    output logic              done,
    output logic [CNT_W-1:0]  words_out
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_READY,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] ks_word_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [WORD_W-1:0] ct_data_reg;
    logic              ct_last_reg;
    logic              ct_valid_reg;
    logic              done_reg;
    logic [CNT_W-1:0]  words_out_reg;
    logic [WORD_W-1:0] xor_word;

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_xor
            assign xor_word[gi] = pt_data[gi] ^ ks_word_reg[gi];
        end
    endgenerate

    // Handshake enables are pure state decodes, so no keystream bit is
    // requested once a full word is held.
    assign ks_gen    = (state_reg == S_FILL);
    assign pt_ready  = (state_reg == S_READY);
    assign ct_valid  = ct_valid_reg;
    assign ct_data   = ct_data_reg;
    assign ct_last   = ct_last_reg;
    assign done      = done_reg;
    assign words_out = words_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FILL;
            ks_word_reg   <= '0;
            bit_cnt_reg   <= '0;
            ct_data_reg   <= '0;
            ct_last_reg   <= 1'b0;
            ct_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            words_out_reg <= '0;
        end else begin
            case (state_reg)
                S_FILL: begin
                    if (ks_rdy) begin
                        ks_word_reg <= {ks_word_reg[WORD_W-2:0], ks_z};
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= S_READY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (pt_valid) begin
                        ct_data_reg  <= xor_word;
                        ct_last_reg  <= pt_last;
                        ct_valid_reg <= 1'b1;
                        state_reg    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ct_ready) begin
                        ct_valid_reg  <= 1'b0;
                        words_out_reg <= words_out_reg + 1'b1;
                        if (ct_last_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg <= S_FILL;
                end
            endcase
        end
    end

endmodule
